// File: rtl/xbar_rob_pkg.sv
// Shared constants and types for the xbar response reorder buffer.
package xbar_rob_pkg;

  localparam int NUM_CH     = 3;
  localparam int ROB_DEPTH  = 8;
  localparam int ROB_IDX_W  = 3;
  localparam int DATA_WIDTH = 128;
  localparam int CH_ID_W    = 2;

  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
  typedef logic [DATA_WIDTH-1:0] beat_t;

endpackage

// File: rtl/xbar_rob_channel.sv
// One channel of the reorder buffer: slot storage, in-order release at head,
// and the credit pulse that follows each release.
module xbar_rob_channel
  import xbar_rob_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     wr_en_i,
  input  rob_idx_t wr_idx_i,
  input  beat_t    wr_data_i,
  output logic     slot_busy_o,
  output logic     rsp_valid_o,
  input  logic     rsp_ready_i,
  output rob_idx_t rsp_rob_num_o,
  output beat_t    rsp_data_o,
  output logic     credit_o
);

  logic [ROB_DEPTH-1:0] vld_q;
  logic [ROB_DEPTH-1:0] vld_d;
  beat_t                mem_q [ROB_DEPTH];
  rob_idx_t             head_q;
  logic                 release_w;

  assign slot_busy_o   = vld_q[wr_idx_i];
  assign rsp_valid_o   = vld_q[head_q];
  assign rsp_rob_num_o = head_q;
  assign rsp_data_o    = mem_q[head_q];
  assign release_w     = rsp_valid_o & rsp_ready_i;

  // A write only lands on an empty slot and a release only clears a full one,
  // so both updates can be applied in the same cycle without conflict.
  always_comb begin
    vld_d = vld_q;
    if (release_w) vld_d[head_q] = 1'b0;
    if (wr_en_i)   vld_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      head_q   <= '0;
      credit_o <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      credit_o <= release_w;
      if (release_w) head_q <= head_q + 1'b1;
    end
  end

  // Payload storage carries no reset; its contents only matter while vld is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

endmodule

// File: rtl/xbar_rsp_rob.sv
// Per-channel response reorder buffer behind the SRAM controller xbar port:
// decodes the channel, muxes ready back and flags beats for unknown channels.
module xbar_rsp_rob
  import xbar_rob_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sc_xbar_valid_i,
  output logic                          sc_xbar_ready_o,
  input  logic [CH_ID_W-1:0]            sc_xbar_channel_id_i,
  input  logic [ROB_IDX_W-1:0]          sc_xbar_rob_num_i,
  input  logic [DATA_WIDTH-1:0]         sc_xbar_data_i,
  output logic [NUM_CH-1:0]             xbar_rsp_valid_o,
  input  logic [NUM_CH-1:0]             xbar_rsp_ready_i,
  output logic [NUM_CH*ROB_IDX_W-1:0]   xbar_rsp_rob_num_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]  xbar_rsp_data_o,
  output logic [NUM_CH-1:0]             xbar_isu_credit_o,
  output logic                          rob_err_o
);

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] slot_busy;
  logic [NUM_CH-1:0] wr_en;
  logic              ch_legal;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_hit[c] = (sc_xbar_channel_id_i == CH_ID_W'(c));
    assign wr_en[c]  = sc_xbar_valid_i & ch_hit[c] & ~slot_busy[c];

    xbar_rob_channel u_channel (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .wr_en_i       (wr_en[c]),
      .wr_idx_i      (sc_xbar_rob_num_i),
      .wr_data_i     (sc_xbar_data_i),
      .slot_busy_o   (slot_busy[c]),
      .rsp_valid_o   (xbar_rsp_valid_o[c]),
      .rsp_ready_i   (xbar_rsp_ready_i[c]),
      .rsp_rob_num_o (xbar_rsp_rob_num_o[c*ROB_IDX_W +: ROB_IDX_W]),
      .rsp_data_o    (xbar_rsp_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .credit_o      (xbar_isu_credit_o[c])
    );
  end

  assign ch_legal = |ch_hit;

  // Unknown channels are always accepted so the controller never wedges on them.
  always_comb begin
    sc_xbar_ready_o = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) sc_xbar_ready_o = ~slot_busy[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rob_err_o <= 1'b0;
    end else if (sc_xbar_valid_i && !ch_legal) begin
      rob_err_o <= 1'b1;
    end
  end

endmodule
